gbd_cart_bus_master: RTL and testbench

GBD_CART_BUS_MASTER -- requirements
Module: gbd_cart_bus_master

---
 rtl/gbd_cart_bus_master.sv | 121 ++++++++++++
 tb/tb_gbd_cart_bus_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbd_cart_bus_master.sv
// Game Boy style cartridge bus master: one request becomes one
// four-quarter bus cycle aligned to the free-running bus clock.
module gbd_cart_bus_master #(
  parameter int QTR = 4
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        cart_CLK,
  output logic [15:0] cart_A,
  output logic [7:0]  cart_D_out,
  output logic        cart_D_oe,
  input  logic [7:0]  cart_D_in,
  output logic        cart_nRD,
  output logic        cart_nWR,
  output logic        cart_nCS
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACTIVE
  } state_t;

  localparam logic [7:0] QMAX = 8'(QTR - 1);

  state_t      st_q, st_d;
  logic [7:0]  q_q, q_d;
  logic [1:0]  p_q, p_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wd_q, wd_d;
  logic        bnd, acc, act_d, hit_d;

  logic        clk_q, nrd_q, nwr_q, ncs_q, oe_q;
  logic [15:0] a_q;
  logic [7:0]  dout_q, rdata_q;
  logic        rsp_q;

  always_comb begin
    bnd    = (p_q == 2'd3) && (q_q == QMAX);
    acc    = req_valid && (st_q == IDLE);
    q_d    = (q_q == QMAX) ? 8'd0 : q_q + 8'd1;
    p_d    = (q_q == QMAX) ? p_q + 2'd1 : p_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    if (acc) begin
      wr_d   = req_write;
      addr_d = req_addr;
      wd_d   = req_wdata;
    end
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (acc) st_d = bnd ? ACTIVE : PEND;
      PEND:    if (bnd) st_d = ACTIVE;
      ACTIVE:  if (bnd) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    act_d = (st_d == ACTIVE);
    hit_d = (addr_d >= 16'hA000) && (addr_d <= 16'hFDFF);
  end

  // Strobes are computed from next-state so they line up with p/q.
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      st_q    <= IDLE;
      q_q     <= '0;
      p_q     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      clk_q   <= 1'b1;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      ncs_q   <= 1'b1;
      oe_q    <= 1'b0;
      a_q     <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      q_q    <= q_d;
      p_q    <= p_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      clk_q  <= ~p_d[1];
      nrd_q  <= ~(act_d && !wr_d);
      nwr_q  <= ~(act_d && wr_d && (p_d == 2'd2));
      ncs_q  <= ~(act_d && hit_d && (p_d != 2'd0));
      oe_q   <= act_d && wr_d && (p_d != 2'd0);
      if (act_d) a_q <= addr_d;
      if (act_d && wr_d) dout_q <= wd_d;
      rsp_q  <= (st_q == ACTIVE) && bnd;
      if ((st_q == ACTIVE) && bnd)
        rdata_q <= wr_q ? 8'h00 : cart_D_in;
    end
  end

  assign req_ready  = (st_q == IDLE);
  assign busy       = (st_q != IDLE);
  assign rsp_valid  = rsp_q;
  assign rsp_rdata  = rdata_q;
  assign cart_CLK   = clk_q;
  assign cart_A     = a_q;
  assign cart_D_out = dout_q;
  assign cart_D_oe  = oe_q;
  assign cart_nRD   = nrd_q;
  assign cart_nWR   = nwr_q;
  assign cart_nCS   = ncs_q;

endmodule

// File: tb/tb_gbd_cart_bus_master.sv
// Directed bench for gbd_cart_bus_master at QTR=4; cycle numbers
// count rising edges since reset release (16 clocks per bus cycle).
module tb_gbd_cart_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic        cart_CLK;
  logic [15:0] cart_A;
  logic [7:0]  cart_D_out;
  logic        cart_D_oe;
  logic [7:0]  cart_D_in = '0;
  logic        cart_nRD, cart_nWR, cart_nCS;

  always #5 clk = ~clk;

  gbd_cart_bus_master #(.QTR(4)) dut (
    .sys_clock (clk),
    .sys_reset (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .cart_CLK  (cart_CLK),
    .cart_A    (cart_A),
    .cart_D_out(cart_D_out),
    .cart_D_oe (cart_D_oe),
    .cart_D_in (cart_D_in),
    .cart_nRD  (cart_nRD),
    .cart_nWR  (cart_nWR),
    .cart_nCS  (cart_nCS)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_cs, n_rd, n_wr, n_oe, n_dbad, n_abad, n_rsp, n_rdf;
  int clk_bad = 0;
  int hold_bad = 0;
  int rsp_at[4];
  int rd_at[4];
  int wr_first;
  logic        prev_nrd, prev_nwr;
  logic [7:0]  last_rd, hold_exp;
  logic [15:0] exp_a;
  logic [7:0]  exp_wd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_cs = 0; n_rd = 0; n_wr = 0; n_oe = 0;
    n_dbad = 0; n_abad = 0; n_rsp = 0; n_rdf = 0;
    wr_first = -1;
    for (int i = 0; i < 4; i++) begin
      rsp_at[i] = -1;
      rd_at[i]  = -1;
    end
    prev_nrd = 1'b1;
    prev_nwr = 1'b1;
    last_rd  = 8'hxx;
  endtask

  task automatic step();
    logic exp_clk;
    @(posedge clk);
    #1;
    cyc++;
    exp_clk = ((cyc % 16) < 8);
    if (cart_CLK !== exp_clk) clk_bad++;
    if (!cart_nRD || !cart_nWR || cart_D_oe)
      if (cart_A !== exp_a) n_abad++;
    if (!cart_nCS) n_cs++;
    if (!cart_nRD) n_rd++;
    if (prev_nrd && !cart_nRD && n_rdf < 4) begin
      rd_at[n_rdf] = cyc;
      n_rdf++;
    end
    if (!cart_nWR) n_wr++;
    if (prev_nwr && !cart_nWR && wr_first < 0) wr_first = cyc;
    if (cart_D_oe) begin
      n_oe++;
      if (cart_D_out !== exp_wd) n_dbad++;
    end
    if (rsp_valid) begin
      if (n_rsp < 4) rsp_at[n_rsp] = cyc;
      n_rsp++;
      last_rd = rsp_rdata;
    end else if (rsp_rdata !== hold_exp) begin
      hold_bad++;
    end
    prev_nrd = cart_nRD;
    prev_nwr = cart_nWR;
  endtask

  task automatic txn(input logic w, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] din);
    exp_a = a;
    exp_wd = wd;
    cart_D_in = din;
    clear_stats();
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_write = ~w;
    req_addr = ~a;
    req_wdata = ~wd;
    for (int i = 0; i < 80 && n_rsp == 0; i++) step();
    chk("rsp_seen", n_rsp, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_a = '0;
    exp_wd = '0;
    hold_exp = 8'h00;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk", cart_CLK, 1);
    chk("rst_A", cart_A, 16'h0000);
    chk("rst_Dout", cart_D_out, 8'h00);
    chk("rst_oe", cart_D_oe, 0);
    chk("rst_nRD", cart_nRD, 1);
    chk("rst_nWR", cart_nWR, 1);
    chk("rst_nCS", cart_nCS, 1);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    cyc = 0;

    // read hit, accepted at p0 q1 boundary-less point k=0
    txn(1'b0, 16'hA000, 8'h00, 8'h5A);
    chk("rd_rsp_cyc", rsp_at[0], 32);
    chk("rd_start", rd_at[0], 16);
    chk("rd_nRD_len", n_rd, 16);
    chk("rd_nCS_len", n_cs, 12);
    chk("rd_nWR_len", n_wr, 0);
    chk("rd_oe_len", n_oe, 0);
    chk("rd_data", last_rd, 8'h5A);
    chk("rd_addr", n_abad, 0);
    chk("rd_A_hold", cart_A, 16'hA000);
    hold_exp = 8'h5A;

    // write outside chip-select window, accepted in rsp cycle
    txn(1'b1, 16'h4000, 8'h10, 8'h77);
    chk("wr_rsp_cyc", rsp_at[0], 64);
    chk("wr_nWR_start", wr_first, 56);
    chk("wr_nWR_len", n_wr, 4);
    chk("wr_oe_len", n_oe, 12);
    chk("wr_dout", n_dbad, 0);
    chk("wr_nCS_len", n_cs, 0);
    chk("wr_nRD_len", n_rd, 0);
    chk("wr_rdata", last_rd, 8'h00);
    chk("wr_addr", n_abad, 0);
    hold_exp = 8'h00;

    txn(1'b0, 16'h9FFF, 8'h00, 8'h11);
    chk("dec_9FFF_cyc", rsp_at[0], 96);
    chk("dec_9FFF_cs", n_cs, 0);
    chk("dec_9FFF_data", last_rd, 8'h11);
    hold_exp = 8'h11;
    txn(1'b0, 16'hFDFF, 8'h00, 8'h22);
    chk("dec_FDFF_cyc", rsp_at[0], 128);
    chk("dec_FDFF_cs", n_cs, 12);
    hold_exp = 8'h22;
    txn(1'b0, 16'hFE00, 8'h00, 8'h33);
    chk("dec_FE00_cyc", rsp_at[0], 160);
    chk("dec_FE00_cs", n_cs, 0);
    hold_exp = 8'h33;

    // phase alignment: accept at p0 q1, then exactly on a boundary
    step();
    txn(1'b0, 16'h2000, 8'h00, 8'h44);
    chk("ph_q1_start", rd_at[0], 176);
    chk("ph_q1_rsp", rsp_at[0], 192);
    hold_exp = 8'h44;
    repeat (15) step();
    txn(1'b0, 16'hA5A5, 8'h00, 8'h55);
    chk("ph_bnd_start", rd_at[0], 208);
    chk("ph_bnd_rsp", rsp_at[0], 224);
    chk("ph_bnd_cs", n_cs, 12);
    chk("ph_bnd_addr", n_abad, 0);
    hold_exp = 8'h55;

    // back-to-back with req_valid held across two transactions
    exp_a = 16'hC000;
    cart_D_in = 8'h66;
    clear_stats();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'hC000;
    step();
    chk("b2b_busy", busy, 1);
    chk("b2b_ready", req_ready, 0);
    for (int i = 0; i < 100 && n_rsp < 2; i++) begin
      step();
      if (n_rsp >= 1) hold_exp = 8'h66;
      if (n_rsp >= 1 && cyc > rsp_at[0]) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("b2b_rsp0", rsp_at[0], 256);
    chk("b2b_rsp1", rsp_at[1], 288);
    chk("b2b_start0", rd_at[0], 240);
    chk("b2b_start1", rd_at[1], 272);
    chk("b2b_nRD_len", n_rd, 32);
    chk("b2b_data", last_rd, 8'h66);

    // reset abort in ACTIVE p=2 of a write
    exp_a = 16'hA100;
    exp_wd = 8'h3C;
    clear_stats();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 16'hA100;
    req_wdata = 8'h3C;
    step();
    req_valid = 1'b0;
    chk("ab_busy", busy, 1);
    chk("ab_ready", req_ready, 0);
    repeat (24) step();
    chk("ab_pre_cyc", cyc, 313);
    chk("ab_pre_nWR", cart_nWR, 0);
    chk("ab_pre_oe", cart_D_oe, 1);
    chk("ab_pre_nCS", cart_nCS, 0);
    chk("ab_pre_dout", cart_D_out, 8'h3C);
    chk("ab_pre_clk", cart_CLK, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_nWR", cart_nWR, 1);
    chk("ab_oe", cart_D_oe, 0);
    chk("ab_nCS", cart_nCS, 1);
    chk("ab_nRD", cart_nRD, 1);
    chk("ab_clk", cart_CLK, 1);
    chk("ab_busy0", busy, 0);
    chk("ab_rdata", rsp_rdata, 8'h00);
    chk("ab_A", cart_A, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    hold_exp = 8'h00;
    clear_stats();
    repeat (40) step();
    chk("ab_no_rsp", n_rsp, 0);
    chk("ab_no_wr", n_wr, 0);
    chk("ab_no_oe", n_oe, 0);
    chk("ab_no_rd", rd_at[0], 32'hFFFF_FFFF);
    chk("clk_pattern", clk_bad, 0);
    chk("rdata_hold", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
